// File: rtl/pad_reader.sv
// Scans two NES (4021) controller pads over latch/clock/data wires and publishes
// each pad as an active-high button byte, updated atomically with a valid pulse.
module pad_reader #(
    parameter int CLKDIV      = 60,
    parameter int POLL_PERIOD = 400000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_req,
    input  logic       pad_data0,
    input  logic       pad_data1,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] input0,
    output logic [7:0] input1,
    output logic       valid
);

    localparam int CNT_W = $clog2(2 * CLKDIV);
    localparam int TMR_W = $clog2(POLL_PERIOD);

    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(2 * CLKDIV - 1);
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(CLKDIV - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift0;
    logic [7:0]       shift1;
    logic [1:0]       sync0;
    logic [1:0]       sync1;

    // Pads idle high (released), so the synchronisers reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 2'b11;
            sync1 <= 2'b11;
        end else begin
            sync0 <= {sync0[0], pad_data0};
            sync1 <= {sync1[0], pad_data1};
        end
    end

    // NOTE: all state is registered with non-blocking assignments so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            timer     <= '0;
            bit_idx   <= '0;
            shift0    <= '0;
            shift1    <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            input0    <= '0;
            input1    <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (timer == '0 || poll_req) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        phase_cnt <= LATCH_LOAD;
                        timer     <= TMR_LOAD;
                    end
                end

                LATCH: begin
                    if (phase_cnt == '0) begin
                        state     <= LOW;
                        pad_latch <= 1'b0;
                        phase_cnt <= PHASE_LOAD;
                        bit_idx   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                LOW: begin
                    if (phase_cnt == '0) begin
                        // Pad lines are active-low; store pressed as 1, first bit ends in [7].
                        shift0 <= {shift0[6:0], ~sync0[1]};
                        shift1 <= {shift1[6:0], ~sync1[1]};
                        if (bit_idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            state     <= HIGH;
                            pad_clk   <= 1'b1;
                            phase_cnt <= PHASE_LOAD;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                HIGH: begin
                    if (phase_cnt == '0) begin
                        state     <= LOW;
                        pad_clk   <= 1'b0;
                        phase_cnt <= PHASE_LOAD;
                        bit_idx   <= bit_idx + 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                DONE: begin
                    input0 <= shift0;
                    input1 <= shift1;
                    valid  <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_reader.sv
// Directed bench for pad_reader with two behavioural 4021 pad models
// (CLKDIV=4, POLL_PERIOD=200).
module tb_pad_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       poll_req = 1'b0;
    logic       pad_data0;
    logic       pad_data1;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] input0;
    logic [7:0] input1;
    logic       valid;

    logic [7:0] btn0 = 8'h00;
    logic [7:0] btn1 = 8'h00;
    logic [7:0] sr0  = 8'hFF;
    logic [7:0] sr1  = 8'hFF;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;

    // Monitor state, updated on the falling edge.
    int latch_rises = 0, latch_rise_cyc = 0, latch_hi_len = 0;
    int pclk_rises_in_poll = 0, clk_hi = 0, bad_width = 0, overlap = 0;
    int valid_cnt = 0, valid_cyc = 0, valid_long = 0, xcnt = 0;
    logic prev_latch = 1'b0, prev_pclk = 1'b0, prev_valid = 1'b0;

    pad_reader #(.CLKDIV(4), .POLL_PERIOD(200)) dut (
        .clk       (clk),
        .rst       (rst),
        .poll_req  (poll_req),
        .pad_data0 (pad_data0),
        .pad_data1 (pad_data1),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .input0    (input0),
        .input1    (input1),
        .valid     (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 4021 model: parallel load on latch, A appears first, shifts on pad_clk rise.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) sr0 <= ~btn0;
        else           sr0 <= {sr0[6:0], 1'b1};
    end
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) sr1 <= ~btn1;
        else           sr1 <= {sr1[6:0], 1'b1};
    end
    assign pad_data0 = sr0[7];
    assign pad_data1 = sr1[7];

    always @(negedge clk) begin
        if (pad_latch && !prev_latch) begin
            latch_rises++;
            latch_rise_cyc     = cyc;
            latch_hi_len       = 0;
            pclk_rises_in_poll = 0;
        end
        if (pad_latch) latch_hi_len++;
        if (pad_clk && !prev_pclk) begin
            pclk_rises_in_poll++;
            clk_hi = 0;
        end
        if (pad_clk) clk_hi++;
        if (!pad_clk && prev_pclk && clk_hi != 4) bad_width++;
        if (pad_clk && pad_latch) overlap++;
        if (valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            if (prev_valid) valid_long++;
        end
        if (!rst && ((^{pad_latch, pad_clk, input0, input1, valid}) === 1'bx)) xcnt++;
        prev_latch = pad_latch;
        prev_pclk  = pad_clk;
        prev_valid = valid;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int start = valid_cnt;
        int n = 0;
        while (valid_cnt == start && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (valid_cnt == start) begin
            errors++;
            $display("FAIL %s: no valid pulse within 400 cycles (got %0d pulses, need 1)", name, valid_cnt - start);
        end
    endtask

    task automatic wait_latch(input string name, input int start);
        int n = 0;
        while (latch_rises == start && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (latch_rises == start) begin
            errors++;
            $display("FAIL %s: no pad_latch rise within 400 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) step();
        checks++;
        if ({pad_latch, pad_clk, valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: latch/clk/valid=%b expected 000", {pad_latch, pad_clk, valid});
        end
        checks++;
        if (input0 !== 8'h00 || input1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_inputs: input0=%h input1=%h expected 00 00", input0, input1);
        end
    endtask

    task automatic test_first_poll();
        btn0 = 8'h81;
        btn1 = 8'h00;
        rst  = 1'b0;
        rel  = cyc;
        wait_valid("first_poll_valid");
        checks++;
        if (latch_rise_cyc - rel != 1) begin
            errors++;
            $display("FAIL first_latch_start: latch rose %0d cycles after release, expected 1", latch_rise_cyc - rel);
        end
        checks++;
        if (input0 !== 8'h81 || input1 !== 8'h00) begin
            errors++;
            $display("FAIL first_poll_data: input0=%h input1=%h expected 81 00", input0, input1);
        end
        checks++;
        if (valid_cyc - latch_rise_cyc != 69) begin
            errors++;
            $display("FAIL latency: valid %0d cycles after latch rise, expected 69", valid_cyc - latch_rise_cyc);
        end
        step();
        checks++;
        if (valid !== 1'b0 || valid_long != 0) begin
            errors++;
            $display("FAIL valid_width: valid=%b long=%0d expected single-cycle pulse", valid, valid_long);
        end
    endtask

    task automatic test_waveform();
        checks++;
        if (latch_hi_len != 8) begin
            errors++;
            $display("FAIL latch_width: %0d cycles expected 8", latch_hi_len);
        end
        checks++;
        if (pclk_rises_in_poll != 7) begin
            errors++;
            $display("FAIL pclk_edges: %0d rising edges expected 7", pclk_rises_in_poll);
        end
        checks++;
        if (bad_width != 0) begin
            errors++;
            $display("FAIL pclk_width: %0d pulses not 4 cycles high, expected 0", bad_width);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL latch_overlap: pad_clk high with pad_latch %0d cycles, expected 0", overlap);
        end
    endtask

    task automatic test_free_run();
        int start = valid_cnt;
        int bad_hold = 0;
        int n = 0;
        btn0 = 8'h10;
        while (valid_cnt == start && n < 400) begin
            if (input0 !== 8'h81) bad_hold++;
            step();
            n++;
        end
        checks++;
        if (valid_cnt == start || bad_hold != 0) begin
            errors++;
            $display("FAIL hold_between_polls: %0d cycles changed early, valid seen=%0d", bad_hold, valid_cnt - start);
        end
        checks++;
        if (latch_rise_cyc - rel != 201) begin
            errors++;
            $display("FAIL second_start: latch at +%0d expected +201", latch_rise_cyc - rel);
        end
        checks++;
        if (input0 !== 8'h10) begin
            errors++;
            $display("FAIL new_data: input0=%h expected 10", input0);
        end
        wait_valid("third_poll_valid");
        checks++;
        if (latch_rise_cyc - rel != 401) begin
            errors++;
            $display("FAIL third_start: latch at +%0d expected +401", latch_rise_cyc - rel);
        end
    endtask

    task automatic test_poll_req();
        int s1, s2, n;
        wait_latch("periodic_start", latch_rises);
        s1 = latch_rise_cyc;
        n = 0;
        while (pad_clk !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        wait_valid("req_in_high_valid");
        wait_latch("next_after_ignored_req", latch_rises);
        checks++;
        if (latch_rise_cyc - s1 != 200) begin
            errors++;
            $display("FAIL req_ignored: next start after %0d cycles expected 200", latch_rise_cyc - s1);
        end
        s2 = latch_rise_cyc;
        wait_valid("poll_before_req_valid");
        n = 0;
        while (cyc != s2 + 99 && n < 300) begin
            step();
            n++;
        end
        n = latch_rises;
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        wait_latch("req_start", n);
        checks++;
        if (latch_rise_cyc - s2 != 100) begin
            errors++;
            $display("FAIL req_immediate: start at +%0d expected +100", latch_rise_cyc - s2);
        end
        s2 = latch_rise_cyc;
        wait_valid("req_poll_valid");
        wait_latch("periodic_after_req", latch_rises);
        checks++;
        if (latch_rise_cyc - s2 != 200) begin
            errors++;
            $display("FAIL req_reload: next start after %0d cycles expected 200", latch_rise_cyc - s2);
        end
    endtask

    task automatic test_reset_abort();
        int v0, n;
        btn1 = 8'h3C;
        n = 0;
        while (pclk_rises_in_poll != 4 && n < 100) begin
            step();
            n++;
        end
        v0 = valid_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rel = cyc;
        checks++;
        if ({pad_latch, pad_clk, valid} !== 3'b000 || valid_cnt != v0) begin
            errors++;
            $display("FAIL abort_ctrl: latch/clk/valid=%b pulses=%0d expected 000 0", {pad_latch, pad_clk, valid}, valid_cnt - v0);
        end
        checks++;
        if (input0 !== 8'h00 || input1 !== 8'h00) begin
            errors++;
            $display("FAIL abort_inputs: input0=%h input1=%h expected 00 00", input0, input1);
        end
        bad_width = 0;
        wait_valid("restart_valid");
        checks++;
        if (latch_rise_cyc - rel != 1 || valid_cyc - latch_rise_cyc != 69) begin
            errors++;
            $display("FAIL restart_timing: start +%0d latency %0d expected +1 69", latch_rise_cyc - rel, valid_cyc - latch_rise_cyc);
        end
        checks++;
        if (input0 !== 8'h10 || input1 !== 8'h3C) begin
            errors++;
            $display("FAIL restart_data: input0=%h input1=%h expected 10 3c", input0, input1);
        end
        checks++;
        if (pclk_rises_in_poll != 7 || bad_width != 0) begin
            errors++;
            $display("FAIL restart_wave: edges=%0d bad=%0d expected 7 0", pclk_rises_in_poll, bad_width);
        end
    endtask

    task automatic test_all_pressed();
        btn0 = 8'h55;
        btn1 = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            wait_valid("all_pressed_valid");
            checks++;
            if (input0 !== 8'h55 || input1 !== 8'hFF) begin
                errors++;
                $display("FAIL all_pressed_poll%0d: input0=%h input1=%h expected 55 ff", p, input0, input1);
            end
        end
        checks++;
        if (xcnt != 0 || valid_long != 0 || overlap != 0) begin
            errors++;
            $display("FAIL output_sanity: x=%0d long_valid=%0d overlap=%0d expected 0 0 0", xcnt, valid_long, overlap);
        end
    endtask

    initial begin
        test_reset();
        test_first_poll();
        test_waveform();
        test_free_run();
        test_poll_req();
        test_reset_abort();
        test_all_pressed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
